// File: rtl/cadr_qreg_pkg.sv
// Shared definitions for the CADR Q register datapath.
// Contents:
//   - Q operation encoding, as presented on {qs1, qs0}.
//   - Register width, shift-step saturation value and counter width.
//   - A helper that decodes the raw select bits into the enum.
package cadr_qreg_pkg;

    localparam int unsigned Q_WIDTH     = 32;
    localparam int unsigned Q_STEP_MAX  = 32;
    localparam int unsigned Q_STEP_BITS = 6;

    // Q operation selected by the Q control block
    typedef enum logic [1:0] {
        QOP_HOLD = 2'b00,
        QOP_SHL  = 2'b01,
        QOP_SHR  = 2'b10,
        QOP_LOAD = 2'b11
    } qop_e;

    // Map the qs1/qs0 pins onto the operation enum
    function automatic qop_e qop_decode(input logic qs1, input logic qs0);
        return qop_e'({qs1, qs0});
    endfunction

endpackage : cadr_qreg_pkg

// File: rtl/cadr_qreg_step_counter.sv
// Saturating shift-step counter for mstep/dstep sequences.
// Ports:
//   clk    in   core clock
//   reset  in   asynchronous active-high reset
//   inc    in   count one more shift step (ignored once saturated)
//   clr    in   return to zero; wins over inc
//   cnt    out  current step count, registered
//   full   out  cnt has reached STEP_MAX (combinational from cnt)
module cadr_qreg_step_counter
    import cadr_qreg_pkg::*;
#(
    parameter int unsigned STEP_MAX = Q_STEP_MAX,
    parameter int unsigned CNT_BITS = Q_STEP_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inc,
    input  logic                clr,
    output logic [CNT_BITS-1:0] cnt,
    output logic                full
);

    logic [CNT_BITS-1:0] cnt_q;
    logic [CNT_BITS-1:0] cnt_d;
    logic                full_c;

    // Saturation detect
    assign full_c = (cnt_q == CNT_BITS'(STEP_MAX));

    // Next count: clear wins, increment stops at STEP_MAX instead of wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !full_c) begin
            cnt_d = cnt_q + CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign full = full_c;

endmodule : cadr_qreg_step_counter

// File: rtl/cadr_q_register.sv
// CADR Q register: 32-bit multiply/divide shift register.
// Holds, shifts or loads from the ALU at the end of each microinstruction
// (state_fetch), gates Q onto the MF bus, counts consecutive shift steps and
// gives the spy port read/write access.
// Ports:
//   clk, reset      core clock, asynchronous active-high reset
//   state_fetch     final microinstruction phase; Q only updates here
//   qs1, qs0        00 hold, 01 shift left, 10 shift right, 11 load
//   qdrive          gate Q onto mf_q this cycle
//   alu             ALU result; top bit is carry out and is not used
//   spy_wr, spy_in  debug write of Q, overrides a same-cycle fetch update
//   spy_rd          debug read request; answered on spy_q/spy_q_valid
//   q               current Q contents
//   mf_q            Q when qdrive, else zero (combinational)
//   spy_q           registered snapshot of Q for spy reads
//   spy_q_valid     one-cycle pulse after each spy_rd
//   step_cnt        consecutive shift steps since last load/clear, saturating
//   step_full       step_cnt == STEP_MAX (combinational)
module cadr_q_register
    import cadr_qreg_pkg::*;
#(
    parameter int unsigned WIDTH    = Q_WIDTH,
    parameter int unsigned STEP_MAX = Q_STEP_MAX
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   state_fetch,
    input  logic                   qs1,
    input  logic                   qs0,
    input  logic                   qdrive,
    input  logic [WIDTH:0]         alu,
    input  logic                   spy_wr,
    input  logic                   spy_rd,
    input  logic [WIDTH-1:0]       spy_in,
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH-1:0]       mf_q,
    output logic [WIDTH-1:0]       spy_q,
    output logic                   spy_q_valid,
    output logic [Q_STEP_BITS-1:0] step_cnt,
    output logic                   step_full
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] spy_q_q;
    logic [WIDTH-1:0] spy_q_d;
    logic             spy_valid_q;
    logic             spy_valid_d;
    logic             step_inc;
    logic             step_clr;
    qop_e             qop;

    // The ALU carry out has no role in the Q datapath
    logic unused_alu_carry;
    assign unused_alu_carry = alu[WIDTH];

    assign qop = qop_decode(qs1, qs0);

    // Q next-state mux and step-counter controls.
    // Shift left feeds in the inverted ALU sign (divide quotient bit);
    // shift right feeds in ALU bit 0 (multiply low-order bit).
    always_comb begin
        q_d      = q_q;
        step_inc = 1'b0;
        step_clr = 1'b0;
        if (spy_wr) begin
            q_d      = spy_in;
            step_clr = 1'b1;
        end else if (state_fetch) begin
            case (qop)
                QOP_HOLD: q_d = q_q;
                QOP_SHL: begin
                    q_d      = {q_q[WIDTH-2:0], ~alu[WIDTH-1]};
                    step_inc = 1'b1;
                end
                QOP_SHR: begin
                    q_d      = {alu[0], q_q[WIDTH-1:1]};
                    step_inc = 1'b1;
                end
                QOP_LOAD: begin
                    q_d      = alu[WIDTH-1:0];
                    step_clr = 1'b1;
                end
                default: q_d = q_q;
            endcase
        end
    end

    // Spy read captures the pre-edge Q, so a coincident update or spy write
    // is not visible in the snapshot
    always_comb begin
        spy_q_d     = spy_q_q;
        spy_valid_d = spy_rd;
        if (spy_rd) begin
            spy_q_d = q_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q         <= '0;
            spy_q_q     <= '0;
            spy_valid_q <= 1'b0;
        end else begin
            q_q         <= q_d;
            spy_q_q     <= spy_q_d;
            spy_valid_q <= spy_valid_d;
        end
    end

    cadr_qreg_step_counter #(
        .STEP_MAX (STEP_MAX),
        .CNT_BITS (Q_STEP_BITS)
    ) u_step_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (step_inc),
        .clr   (step_clr),
        .cnt   (step_cnt),
        .full  (step_full)
    );

    // MF bus gating is combinational so Q appears in the same cycle as qdrive
    assign mf_q        = qdrive ? q_q : '0;
    assign q           = q_q;
    assign spy_q       = spy_q_q;
    assign spy_q_valid = spy_valid_q;

endmodule : cadr_q_register

// File: tb/tb_cadr_q_register.sv
// Self-checking bench for cadr_q_register: directed scenarios plus random
// stimulus compared every cycle against a behavioural model of Q.
module tb_cadr_q_register;
    import cadr_qreg_pkg::*;

    localparam int unsigned W = Q_WIDTH;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   state_fetch;
    logic                   qs1;
    logic                   qs0;
    logic                   qdrive;
    logic [W:0]             alu;
    logic                   spy_wr;
    logic                   spy_rd;
    logic [W-1:0]           spy_in;
    logic [W-1:0]           q;
    logic [W-1:0]           mf_q;
    logic [W-1:0]           spy_q;
    logic                   spy_q_valid;
    logic [Q_STEP_BITS-1:0] step_cnt;
    logic                   step_full;

    cadr_q_register dut (
        .clk         (clk),
        .reset       (reset),
        .state_fetch (state_fetch),
        .qs1         (qs1),
        .qs0         (qs0),
        .qdrive      (qdrive),
        .alu         (alu),
        .spy_wr      (spy_wr),
        .spy_rd      (spy_rd),
        .spy_in      (spy_in),
        .q           (q),
        .mf_q        (mf_q),
        .spy_q       (spy_q),
        .spy_q_valid (spy_q_valid),
        .step_cnt    (step_cnt),
        .step_full   (step_full)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural reference state
    logic [W-1:0] q_m;
    logic [W-1:0] spy_m;
    logic         spyv_m;
    int           cnt_m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_m    = '0;
        spy_m  = '0;
        spyv_m = 1'b0;
        cnt_m  = 0;
    endtask

    // Apply one clock edge's worth of spec rules to the model
    task automatic model_edge();
        int op;
        op = {qs1, qs0};
        if (spy_rd) begin
            spy_m  = q_m;
            spyv_m = 1'b1;
        end else begin
            spyv_m = 1'b0;
        end
        if (spy_wr) begin
            q_m   = spy_in;
            cnt_m = 0;
        end else if (state_fetch) begin
            if (op == 1) begin
                q_m   = (q_m << 1) | W'(!alu[W-1]);
                cnt_m = (cnt_m + 1 > int'(Q_STEP_MAX)) ? int'(Q_STEP_MAX) : cnt_m + 1;
            end else if (op == 2) begin
                q_m   = (q_m >> 1) | (W'(alu[0]) << (W - 1));
                cnt_m = (cnt_m + 1 > int'(Q_STEP_MAX)) ? int'(Q_STEP_MAX) : cnt_m + 1;
            end else if (op == 3) begin
                q_m   = alu[W-1:0];
                cnt_m = 0;
            end
        end
    endtask

    task automatic check_all();
        check("q",           64'(q),           64'(q_m));
        check("mf_q",        64'(mf_q),        qdrive ? 64'(q_m) : 64'd0);
        check("spy_q",       64'(spy_q),       64'(spy_m));
        check("spy_q_valid", 64'(spy_q_valid), 64'(spyv_m));
        check("step_cnt",    64'(step_cnt),    64'(cnt_m));
        check("step_full",   64'(step_full),   64'(cnt_m == int'(Q_STEP_MAX)));
    endtask

    // Inputs are stable from the previous falling edge; check at the next one
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        state_fetch = 1'b0;
        qs1 = 1'b0;
        qs0 = 1'b0;
        qdrive = 1'b0;
        alu = '0;
        spy_wr = 1'b0;
        spy_rd = 1'b0;
        spy_in = '0;
    endtask

    task automatic set_op(input logic fetch, input logic [1:0] op, input logic [W:0] a);
        state_fetch = fetch;
        qs1 = op[1];
        qs0 = op[0];
        alu = a;
    endtask

    initial begin
        logic [W:0] a;
        model_reset();
        idle();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_all();
        check("reset_q", 64'(q), 64'd0);
        reset = 1'b0;

        // Load from ALU
        set_op(1'b1, QOP_LOAD, 33'h0_DEADBEEF);
        cycle();
        check("load_q", 64'(q), 64'hDEADBEEF);
        check("load_cnt", 64'(step_cnt), 64'd0);

        // Shift left then shift right
        set_op(1'b1, QOP_LOAD, 33'h0_80000001);
        cycle();
        set_op(1'b1, QOP_SHL, 33'h0_00000000);
        cycle();
        check("shl_q", 64'(q), 64'h00000003);
        set_op(1'b1, QOP_SHR, 33'h0_00000001);
        cycle();
        check("shr_q", 64'(q), 64'h80000001);
        check("shr_cnt", 64'(step_cnt), 64'd2);

        // Saturation over 40 shift steps
        set_op(1'b1, QOP_LOAD, 33'h0_00000000);
        cycle();
        for (int i = 0; i < 40; i++) begin
            a = {1'b0, $urandom()};
            set_op(1'b1, QOP_SHL, a);
            cycle();
            check("sat_cnt", 64'(step_cnt), (i + 1 >= 32) ? 64'd32 : 64'(i + 1));
            check("sat_full", 64'(step_full), (i >= 31) ? 64'd1 : 64'd0);
        end
        set_op(1'b1, QOP_LOAD, 33'h1_0F0F0F0F);
        cycle();
        check("unsat_cnt", 64'(step_cnt), 64'd0);
        check("unsat_full", 64'(step_full), 64'd0);

        // No update outside state_fetch; MF gating
        set_op(1'b0, QOP_LOAD, 33'h0_AAAA5555);
        qdrive = 1'b1;
        cycle();
        check("nofetch_q", 64'(q), 64'h0F0F0F0F);
        check("mf_on", 64'(mf_q), 64'h0F0F0F0F);
        qdrive = 1'b0;
        #1;
        check("mf_off", 64'(mf_q), 64'd0);

        // Spy write overrides a coincident load
        set_op(1'b1, QOP_SHL, 33'h0_00000000);
        cycle();
        set_op(1'b1, QOP_LOAD, 33'h0_FFFFFFFF);
        spy_wr = 1'b1;
        spy_in = 32'h12345678;
        cycle();
        check("spywr_q", 64'(q), 64'h12345678);
        check("spywr_cnt", 64'(step_cnt), 64'd0);
        spy_wr = 1'b0;

        // Spy read, single pulse
        set_op(1'b1, QOP_LOAD, 33'h0_CAFEF00D);
        cycle();
        set_op(1'b0, QOP_HOLD, '0);
        spy_rd = 1'b1;
        cycle();
        check("spyrd_q", 64'(spy_q), 64'hCAFEF00D);
        check("spyrd_v", 64'(spy_q_valid), 64'd1);
        spy_rd = 1'b0;
        cycle();
        check("spyrd_v_drop", 64'(spy_q_valid), 64'd0);

        // Spy read with spy write on the same edge
        spy_rd = 1'b1;
        spy_wr = 1'b1;
        spy_in = 32'h11111111;
        cycle();
        check("spyrw_old", 64'(spy_q), 64'hCAFEF00D);
        check("spyrw_new", 64'(q), 64'h11111111);
        spy_rd = 1'b0;
        spy_wr = 1'b0;

        // Asynchronous reset mid shift sequence
        for (int i = 0; i < 5; i++) begin
            set_op(1'b1, QOP_SHR, {1'b0, $urandom()});
            cycle();
        end
        check("pre_rst_cnt", 64'(step_cnt), 64'd5);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("arst_q", 64'(q), 64'd0);
        check("arst_cnt", 64'(step_cnt), 64'd0);
        check("arst_spyv", 64'(spy_q_valid), 64'd0);
        check_all();
        @(negedge clk);
        check_all();
        reset = 1'b0;
        idle();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            a = {1'($urandom()), $urandom()};
            set_op(($urandom_range(0, 3) != 0), 2'($urandom()), a);
            qdrive = 1'($urandom());
            spy_wr = ($urandom_range(0, 15) == 0);
            spy_rd = ($urandom_range(0, 3) == 0);
            spy_in = $urandom();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_cadr_q_register
